// File: rtl/ysyx_23060061_alu_pkg.sv
// Shared ALU op encodings and widths for the ALU arbiter and its response slots.
package ysyx_23060061_alu_pkg;
  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD    = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_PASSB  = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_ADDCLR = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SUB    = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU   = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_OP_MAX = 4'd4;

  function automatic logic op_illegal(input logic [ALU_OP_W-1:0] op,
                                      input logic [ALU_OP_W-1:0] op_max);
    return op > op_max;
  endfunction
endpackage

// File: rtl/ysyx_23060061_alu_rsp_slot.sv
// Single-entry response buffer: fill on grant, drain on ready, or both in one edge.
module ysyx_23060061_alu_rsp_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_fill,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_err,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_err
);
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_err;

  // A fill takes precedence over a drain, which gives drain+refill for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_err   <= i_err;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_err   = r_err;
endmodule

// File: rtl/ysyx_23060061_alu_arb.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Optional performance counters are enabled by defining YSYX_23060061_ALU_ARB_PERF_EN.
module ysyx_23060061_alu_arb
  import ysyx_23060061_alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int OP_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [WIDTH-1:0]    req0_a,
  input  logic [WIDTH-1:0]    req0_b,
  input  logic [ALU_OP_W-1:0] req0_op,
  output logic                rsp0_valid,
  input  logic                rsp0_ready,
  output logic [WIDTH-1:0]    rsp0_data,
  output logic                rsp0_err,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [WIDTH-1:0]    req1_a,
  input  logic [WIDTH-1:0]    req1_b,
  input  logic [ALU_OP_W-1:0] req1_op,
  output logic                rsp1_valid,
  input  logic                rsp1_ready,
  output logic [WIDTH-1:0]    rsp1_data,
  output logic                rsp1_err,
`ifdef YSYX_23060061_ALU_ARB_PERF_EN
  output logic [31:0]         perf_grant0,
  output logic [31:0]         perf_grant1,
  output logic [31:0]         perf_conflict,
`endif
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  output logic [ALU_OP_W-1:0] alu_op,
  input  logic [WIDTH-1:0]    alu_out
);
  localparam logic [ALU_OP_W-1:0] W_OP_MAX = OP_MAX[ALU_OP_W-1:0];

  logic [1:0]          w_req_valid, w_rsp_ready, w_rsp_valid, w_rsp_err;
  logic [1:0]          w_elig, w_grant, w_illegal;
  logic [WIDTH-1:0]    w_req_a [2];
  logic [WIDTH-1:0]    w_req_b [2];
  logic [ALU_OP_W-1:0] w_req_op [2];
  logic [WIDTH-1:0]    w_rsp_data [2];
  logic                r_ptr;

  assign w_req_valid = {req1_valid, req0_valid};
  assign w_rsp_ready = {rsp1_ready, rsp0_ready};
  assign w_req_a[0] = req0_a;  assign w_req_a[1] = req1_a;
  assign w_req_b[0] = req0_b;  assign w_req_b[1] = req1_b;
  assign w_req_op[0] = req0_op; assign w_req_op[1] = req1_op;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign w_elig[gi]    = w_req_valid[gi] && (!w_rsp_valid[gi] || w_rsp_ready[gi]);
      assign w_illegal[gi] = op_illegal(w_req_op[gi], W_OP_MAX);

      ysyx_23060061_alu_rsp_slot #(.WIDTH(WIDTH)) u_slot (
        .clk     (clk),
        .rst     (rst),
        .i_fill  (w_grant[gi]),
        .i_data  (w_illegal[gi] ? '0 : alu_out),
        .i_err   (w_illegal[gi]),
        .i_ready (w_rsp_ready[gi]),
        .o_valid (w_rsp_valid[gi]),
        .o_data  (w_rsp_data[gi]),
        .o_err   (w_rsp_err[gi])
      );
    end
  endgenerate

  // Nothing is accepted while reset is asserted, so a request in that cycle is dropped.
  assign w_grant[0] = !rst && w_elig[0] && (!w_elig[1] || !r_ptr);
  assign w_grant[1] = !rst && w_elig[1] && (!w_elig[0] ||  r_ptr);

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];
  assign rsp0_valid = w_rsp_valid[0];
  assign rsp1_valid = w_rsp_valid[1];
  assign rsp0_data  = w_rsp_data[0];
  assign rsp1_data  = w_rsp_data[1];
  assign rsp0_err   = w_rsp_err[0];
  assign rsp1_err   = w_rsp_err[1];

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_ADD;
    if (w_grant[0]) begin
      alu_a  = w_req_a[0];
      alu_b  = w_req_b[0];
      alu_op = w_illegal[0] ? ALU_ADD : w_req_op[0];
    end else if (w_grant[1]) begin
      alu_a  = w_req_a[1];
      alu_b  = w_req_b[1];
      alu_op = w_illegal[1] ? ALU_ADD : w_req_op[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)             r_ptr <= 1'b0;
    else if (w_grant[0]) r_ptr <= 1'b1;
    else if (w_grant[1]) r_ptr <= 1'b0;
  end

`ifdef YSYX_23060061_ALU_ARB_PERF_EN
  logic [31:0] r_grant0_cnt, r_grant1_cnt, r_conflict_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant0_cnt   <= '0;
      r_grant1_cnt   <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_grant[0]) r_grant0_cnt   <= r_grant0_cnt + 32'd1;
      if (w_grant[1]) r_grant1_cnt   <= r_grant1_cnt + 32'd1;
      if (&w_elig)    r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end

  assign perf_grant0   = r_grant0_cnt;
  assign perf_grant1   = r_grant1_cnt;
  assign perf_conflict = r_conflict_cnt;
`endif
endmodule

// File: doc/ysyx_23060061_alu_arb.md
Name: ysyx_23060061_alu_arb

Overview:
Two-requester round-robin arbiter that time-shares one combinational ALU (ops: 0 add, 1 pass-B, 2 add-clear-LSB, 3 sub, 4 sltu) between the EXU and the LSU address path. Requests arrive on valid/ready channels. Each grant drives the ALU for one cycle and registers the result into a per-requester response buffer. The block sits between the issue logic and the shared ALU instance; the ALU instance is external.

Parameters:
WIDTH, 32, operand/result width
OP_MAX, 4, highest legal aluOp encoding; ops above it are illegal

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle when valid&ready
req0_a  in  WIDTH  operand A
req0_b  in  WIDTH  operand B
req0_op  in  4  aluOp code
rsp0_valid  out  1  requester 0 result available
rsp0_ready  in  1  requester 0 consumes result
rsp0_data  out  WIDTH  result
rsp0_err  out  1  result came from illegal op
req1_*/rsp1_*  same as requester 0, for requester 1
alu_a  out  WIDTH  to shared ALU operand A
alu_b  out  WIDTH  to shared ALU operand B
alu_op  out  4  to shared ALU op select
alu_out  in  WIDTH  from shared ALU (combinational)

Behaviour:
- One clock domain. Reset is synchronous, active-high, sampled on the rising edge of clk.
- Reset values: rsp*_valid=0, rsp*_err=0, rsp*_data=0, priority pointer=0 (requester 0 favoured), counters=0.
- Eligibility: requester i is eligible when req_i_valid && (!rsp_i_valid || rsp_i_ready), i.e. its response slot is empty or drains this cycle.
- Grant: at most one per cycle.
  - Only one requester eligible: grant it.
  - Both eligible: grant the one named by the priority pointer.
  - After any grant to i, pointer := 1-i. With no grant, the pointer holds.
- req_i_ready = grant_i, combinational from valid and rsp state. A non-granted ready never depends on its own req_valid beyond eligibility.
- ALU drive: alu_a/alu_b/alu_op = granted requester's operands. With no grant, drive zeros and op 0.
- Latency: request accepted at edge t; rsp_i_valid=1 and rsp_i_data=alu_out captured at edge t. Visible in cycle t+1. Throughput is 1 op/cycle total.
- Response slot: rsp_i_valid clears on rsp_i_valid&&rsp_i_ready unless a new grant to i occurs the same edge, in which case it stays 1 with the new data (drain+refill).
- Illegal op (op > OP_MAX): still granted and consumes a cycle. rsp_i_data=0, rsp_i_err=1. The ALU is driven with op 0. For legal ops, rsp_i_err=0.
- Response data and err hold stable while rsp_i_valid && !rsp_i_ready.
- Back-pressure: with slot i full and not draining, req_i_ready=0 and requester j may proceed unaffected.
- rst asserted mid-operation: pending responses are discarded, outputs take reset values at that edge, and any request presented that cycle is not accepted.
- Operand width rules (external ALU): sltu is an unsigned compare; add/sub wrap modulo 2^WIDTH.

Optional Feature:
Macro YSYX_23060061_ALU_ARB_PERF_EN.
- Defined: adds 32-bit counters grant0_cnt, grant1_cnt and conflict_cnt (both eligible in the same cycle), exposed as output ports perf_grant0, perf_grant1, perf_conflict.
  - Counters reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent; function is otherwise identical.

Decomposition:
- Shared package ysyx_23060061_alu_pkg holds:
  - ALU op localparams (ALU_ADD=0, ALU_PASSB=1, ALU_ADDCLR=2, ALU_SUB=3, ALU_SLTU=4, ALU_OP_MAX=4)
  - ALU_OP_W=4
- One natural sub-module, ysyx_23060061_alu_rsp_slot: single-entry response buffer (valid/data/err, fill, drain, drain+refill). Instantiated twice.

Test Plan:
- Single op: after reset, req0 add a=5 b=7, rsp0_ready=1 -> req0_ready=1 that cycle; next cycle rsp0_valid=1, rsp0_data=12, rsp0_err=0.
- Contention: both valid every cycle, both rsp_ready=1; req0 sub 10-3, req1 sltu 2<9 -> grants alternate 0,1,0,1; first results 7 then 1. Pointer starts at requester 0.
- Back-pressure: rsp0_ready=0 with slot 0 full -> req0_ready=0; req1 granted every cycle; rsp0_data holds value. Releasing rsp0_ready performs drain+refill in the same cycle.
- Illegal op: req1 op=7 a=1 b=1 -> granted; next cycle rsp1_valid=1, rsp1_data=0, rsp1_err=1; alu_op driven 0.
- Wrap/edge: add 0xFFFFFFFF+1 -> 0; op2 a=3 b=4 -> 6; sub 0-1 -> 0xFFFFFFFF.
- Mid-op reset: grant req0 at cycle t, assert rst at t+1 -> rsp0_valid=0 at t+2, pointer back to 0; with PERF_EN, all counters read 0.
